// File: rtl/seqgen_pkg.sv
// Shared types and defaults for the serial pattern generator
// and its loopback detector benches.
package seqgen_pkg;

  localparam int SEQ_WIDTH = 5;
  localparam int SEQ_CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    DONE
  } state_e;

endpackage

// File: rtl/pattern_shifter.sv
// MSB-first shifter: keeps the captured pattern so each copy
// can be replayed without going back to the input port.
import seqgen_pkg::*;

module pattern_shifter #(
  parameter int WIDTH = SEQ_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             shift,
  input  logic             reload,
  input  logic [WIDTH-1:0] din,
  output logic             next_bit,
  output logic             pat_msb
);

  logic [WIDTH-1:0] pat_q;
  logic [WIDTH-1:0] sh_q;

  // sh_q is held one bit ahead: its MSB is the bit after the
  // one currently driven on the registered output.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pat_q <= '0;
      sh_q  <= '0;
    end else if (load) begin
      pat_q <= din;
      sh_q  <= {din[WIDTH-2:0], 1'b0};
    end else if (reload) begin
      sh_q  <= {pat_q[WIDTH-2:0], 1'b0};
    end else if (shift) begin
      sh_q  <= {sh_q[WIDTH-2:0], 1'b0};
    end
  end

  assign next_bit = sh_q[WIDTH-1];
  assign pat_msb  = pat_q[WIDTH-1];

endmodule

// File: rtl/programmable_sequence_generator.sv
// Serializes a captured pattern MSB-first, repeated a set
// number of times back-to-back, with registered outputs.
import seqgen_pkg::*;

module programmable_sequence_generator #(
  parameter int WIDTH = SEQ_WIDTH,
  parameter int CNT_W = SEQ_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] init,
  input  logic [CNT_W-1:0] reps,
  input  logic             start,
  input  logic             abort,
  output logic             dout,
  output logic             dout_valid,
  output logic             frame_start,
  output logic             busy,
  output logic             done
);

  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(WIDTH - 1);

  state_e           state;
  logic [IDX_W-1:0] idx;
  logic [CNT_W-1:0] remaining;

  logic accept;
  logic last_bit;
  logic last_copy;
  logic sh_en;
  logic rl_en;
  logic sh_bit;
  logic pat_msb;

  assign accept    = (state == IDLE) && start;
  assign last_bit  = (idx == '0);
  assign last_copy = (remaining == CNT_W'(1));
  assign sh_en     = (state == SEND) && !abort && !last_bit;
  assign rl_en     = (state == SEND) && !abort && last_bit
                     && !last_copy;

  pattern_shifter #(
    .WIDTH (WIDTH)
  ) u_shifter (
    .clk      (clk),
    .reset    (reset),
    .load     (accept),
    .shift    (sh_en),
    .reload   (rl_en),
    .din      (init),
    .next_bit (sh_bit),
    .pat_msb  (pat_msb)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      idx         <= '0;
      remaining   <= '0;
      dout        <= 1'b0;
      dout_valid  <= 1'b0;
      frame_start <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      dout        <= 1'b0;
      dout_valid  <= 1'b0;
      frame_start <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            remaining <= reps;
            busy      <= 1'b1;
            if (reps != '0) begin
              state       <= SEND;
              idx         <= IDX_TOP;
              dout        <= init[WIDTH-1];
              dout_valid  <= 1'b1;
              frame_start <= 1'b1;
            end else begin
              state <= DONE;
              done  <= 1'b1;
            end
          end
        end
        SEND: begin
          if (abort) begin
            state     <= IDLE;
            idx       <= '0;
            remaining <= '0;
          end else if (!last_bit) begin
            idx        <= idx - 1'b1;
            dout       <= sh_bit;
            dout_valid <= 1'b1;
            busy       <= 1'b1;
          end else if (!last_copy) begin
            remaining   <= remaining - 1'b1;
            idx         <= IDX_TOP;
            dout        <= pat_msb;
            dout_valid  <= 1'b1;
            frame_start <= 1'b1;
            busy        <= 1'b1;
          end else begin
            remaining <= '0;
            state     <= DONE;
            done      <= 1'b1;
            busy      <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_programmable_sequence_generator.sv
// Scoreboard bench: stimulus queues expected bits/done pulses,
// a negedge monitor pops and compares them as they appear.
module tb_programmable_sequence_generator;

  logic       clk;
  logic       reset;
  logic [4:0] init;
  logic [3:0] reps;
  logic       start;
  logic       abort;
  logic       dout;
  logic       dout_valid;
  logic       frame_start;
  logic       busy;
  logic       done;

  programmable_sequence_generator #(
    .WIDTH (5),
    .CNT_W (4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .init        (init),
    .reps        (reps),
    .start       (start),
    .abort       (abort),
    .dout        (dout),
    .dout_valid  (dout_valid),
    .frame_start (frame_start),
    .busy        (busy),
    .done        (done)
  );

  typedef struct {
    bit kind;
    bit b;
    bit fs;
    int cyc;
  } exp_t;

  exp_t sbq[$];
  int   cyc;
  int   n_chk;
  int   n_fail;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string nm, int act, int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)",
               nm, act, exp, cyc);
    end
  endfunction

  always @(negedge clk) begin
    if (!reset) begin
      if (!dout_valid) chk("dout_zero_when_invalid", dout, 0);
      if (dout_valid || done) begin
        if (sbq.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_output: valid=%0b done=%0b cycle %0d",
                   dout_valid, done, cyc);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          chk("kind_done", done, e.kind);
          chk("out_cycle", cyc, e.cyc);
          chk("busy_with_out", busy, 1);
          if (!e.kind) begin
            chk("dout_bit", dout, e.b);
            chk("frame_start", frame_start, e.fs);
          end else begin
            chk("valid_in_done", dout_valid, 0);
          end
        end
      end
    end
  end

  // Call right after a negedge: the next edge accepts the start.
  task automatic start_run(input logic [4:0] pat, input logic [3:0] r,
                           input int nbits, input bit exp_done);
    int c;
    c = cyc;
    for (int k = 0; k < nbits; k++) begin
      exp_t e;
      e.kind = 1'b0;
      e.b    = pat[4 - (k % 5)];
      e.fs   = ((k % 5) == 0);
      e.cyc  = c + 1 + k;
      sbq.push_back(e);
    end
    if (exp_done) begin
      exp_t d;
      d.kind = 1'b1;
      d.b    = 1'b0;
      d.fs   = 1'b0;
      d.cyc  = c + 1 + 5 * int'(r);
      sbq.push_back(d);
    end
    init  = pat;
    reps  = r;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Returns at the first negedge with busy low.
  task automatic wait_idle(input string nm, input int exp_busy);
    int n;
    bit ok;
    n  = 0;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (busy) n++;
      else begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s: busy timeout got %0d expected %0d",
               nm, n, exp_busy);
    end else begin
      chk(nm, n, exp_busy);
    end
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_dout"}, dout, 0);
    chk({nm, "_valid"}, dout_valid, 0);
    chk({nm, "_fs"}, frame_start, 0);
    chk({nm, "_busy"}, busy, 0);
    chk({nm, "_done"}, done, 0);
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    reset  = 1'b1;
    init   = '0;
    reps   = '0;
    start  = 1'b0;
    abort  = 1'b0;
    repeat (2) @(negedge clk);
    chk_all_zero("reset");
    reset = 1'b0;

    @(negedge clk);
    start_run(5'b10110, 4'd1, 5, 1'b1);
    wait_idle("busy_len_r1", 6);

    start_run(5'b00011, 4'd3, 15, 1'b1);
    wait_idle("busy_len_r3", 16);

    start_run(5'b10101, 4'd0, 0, 1'b1);
    wait_idle("busy_len_r0", 1);

    // Second start with new operands while sending is dropped.
    start_run(5'b11100, 4'd2, 10, 1'b1);
    repeat (3) @(negedge clk);
    init  = 5'b00001;
    reps  = 4'd5;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_idle("busy_len_ignored", 8);

    // Abort at edge N+3, restart at edge N+4.
    start_run(5'b10110, 4'd2, 3, 1'b0);
    repeat (3) @(negedge clk);
    abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    @(negedge clk);
    chk_all_zero("after_abort");
    start_run(5'b01010, 4'd1, 5, 1'b1);
    wait_idle("busy_len_post_abort", 6);

    // Asynchronous reset in the middle of a run.
    start_run(5'b11011, 4'd2, 2, 1'b0);
    repeat (2) @(negedge clk);
    #2 reset = 1'b1;
    #1 chk_all_zero("async_reset");
    @(negedge clk);
    #2 reset = 1'b0;
    @(negedge clk);
    start_run(5'b01010, 4'd1, 5, 1'b1);
    wait_idle("busy_len_post_reset", 6);

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", sbq.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
